// File: rtl/fifo_pkg.sv
// Shared types and constants for the byte-FIFO word packer.
// Holds FSM state encoding, byte width and default lane count.
package fifo_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_LANES = 4;
  localparam int CNT_W     = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-deep byte FIFO and packs LANES of them into a
// little-endian word on a valid/ready stream (first byte -> [7:0]).
// Ports: clk, rst_n (async, active-low), fifo_empty/fifo_rd_en/fifo_data
// (FIFO read port, data one cycle after pop), out_data/out_valid/
// out_ready/out_bytes (word stream), busy (partial word or pop in flight),
// flush (only with PACKER_FLUSH_EN: emit a partial word early).
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [BYTE_W-1:0]       fifo_data,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef PACKER_FLUSH_EN
  input  logic                    flush,
`endif
  output logic [CNT_W-1:0]        out_bytes,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LANES - 1);

  state_t state, state_nx;

  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic              rd_pend;
  logic [BYTE_W-1:0] lanes [LANES];

  logic cap_last;
  logic hs;
  logic flush_go;
  logic pop_block;

  assign cap_last = rd_pend && (cap_cnt == LAST_C);
  assign hs       = (state == HOLD) && out_ready;

`ifdef PACKER_FLUSH_EN
  logic flush_req;
  logic flush_hit;

  // A flush counts only while something is held or in flight.
  assign flush_hit = flush && (state == FILL)
                  && ((cap_cnt != '0) || rd_pend);
  // Wait for the in-flight byte before closing the word.
  assign flush_go  = flush_req && !rd_pend && (state == FILL);
  // Stop popping in the pulse cycle too, so only bytes
  // already requested end up in the flushed word.
  assign pop_block = flush_req || flush_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_req <= 1'b0;
    end else if (cap_last || flush_go) begin
      flush_req <= 1'b0;
    end else if (flush_hit) begin
      flush_req <= 1'b1;
    end
  end
`else
  assign flush_go  = 1'b0;
  assign pop_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: begin
        if (cap_last || flush_go) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // rst_n gating keeps the pop request low while reset is held.
  always_comb begin
    fifo_rd_en = rst_n
              && (state == FILL)
              && !fifo_empty
              && (req_cnt < LANES_C)
              && !pop_block;
    out_valid  = (state == HOLD);
    busy       = (cap_cnt != '0) || rd_pend
              || (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt   <= '0;
      cap_cnt   <= '0;
      rd_pend   <= 1'b0;
      out_bytes <= '0;
      for (int i = 0; i < LANES; i++) begin
        lanes[i] <= '0;
      end
    end else begin
      rd_pend <= fifo_rd_en;
      if (hs) begin
        req_cnt   <= '0;
        cap_cnt   <= '0;
        out_bytes <= '0;
        for (int i = 0; i < LANES; i++) begin
          lanes[i] <= '0;
        end
      end else begin
        if (fifo_rd_en) begin
          req_cnt <= req_cnt + 1'b1;
        end
        if (rd_pend) begin
          for (int i = 0; i < LANES; i++) begin
            if (cap_cnt == CNT_W'(i)) begin
              lanes[i] <= fifo_data;
            end
          end
          cap_cnt <= cap_cnt + 1'b1;
        end
        if (cap_last) begin
          out_bytes <= LANES_C;
        end else if (flush_go) begin
          out_bytes <= cap_cnt;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*BYTE_W +: BYTE_W] = lanes[i];
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed + randomized bench for fifo_word_packer with a byte FIFO
// model and a byte-queue reference; PACKER_FLUSH_EN adds a flush phase.
module tb_fifo_word_packer;

  localparam int L = 4;

  logic           clk;
  logic           rst_n;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [7:0]     fifo_data;
  logic [8*L-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     out_bytes;
  logic           busy;
`ifdef PACKER_FLUSH_EN
  logic           flush;
`endif

  fifo_word_packer #(.LANES(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef PACKER_FLUSH_EN
    .flush      (flush),
`endif
    .out_bytes  (out_bytes),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte FIFO model, 8 deep, registered read data.
  logic       push_valid;
  logic [7:0] push_byte;
  logic       hide;
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] fcnt;
  logic       do_push, do_pop;

  assign do_push    = push_valid && (fcnt != 4'd8);
  assign do_pop     = fifo_rd_en && (fcnt != 4'd0);
  assign fifo_empty = (fcnt == 4'd0) || hide;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      fcnt      <= '0;
      fifo_data <= '0;
    end else begin
      if (do_pop) begin
        fifo_data <= mem[rp];
        rp        <= rp + 3'd1;
      end
      if (do_push) begin
        mem[wp] <= push_byte;
        wp      <= wp + 3'd1;
      end
      fcnt <= fcnt + {3'b0, do_push} - {3'b0, do_pop};
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pops  = 0;
  bit tog   = 0;
  bit rnd   = 0;
  bit busy_low;
  bit hold_prev = 0;
  logic [8*L-1:0] prev_data;
  logic [3:0]     prev_bytes;

  logic [7:0]     exp_q [$];
  logic [8*L-1:0] got_q [$];
  logic [3:0]     gotb_q [$];
  int             hs_q [$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (tog) hide = ~hide;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (rst_n) begin
      chk("rd_en_while_empty",
          64'(fifo_rd_en && fifo_empty), 64'd0);
      if (fifo_rd_en) pops++;
      if (!busy) busy_low = 1;
      if (hold_prev) begin
        chk("hold_data", 64'(out_data), 64'(prev_data));
        chk("hold_bytes", 64'(out_bytes), 64'(prev_bytes));
        chk("hold_valid", 64'(out_valid), 64'd1);
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bytes = out_bytes;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        gotb_q.push_back(out_bytes);
        hs_q.push_back(cyc);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    for (int k = 0; k < 200 && fcnt == 4'd8; k++) tick();
    push_valid = 1'b1;
    push_byte  = b;
    exp_q.push_back(b);
    tick();
    push_valid = 1'b0;
  endtask

  function automatic logic [63:0] take(input int n);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = w | (64'(exp_q.pop_front()) << (8 * i));
    end
    return w;
  endfunction

  task automatic check_words(input int n, input int nb,
                             input int limit);
    logic [8*L-1:0] d;
    logic [3:0]     b;
    for (int k = 0; k < limit && got_q.size() < n; k++) tick();
    chk("words_arrived", 64'(got_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (got_q.size() > 0) begin
        d = got_q.pop_front();
        b = gotb_q.pop_front();
        chk("word", 64'(d), take(nb));
        chk("bytes", 64'(b), 64'(nb));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_bytes"}, 64'(out_bytes), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
  endtask

  initial begin
    int p0;
    rst_n      = 1'b0;
    hide       = 1'b0;
    out_ready  = 1'b0;
    push_valid = 1'b0;
    push_byte  = '0;
`ifdef PACKER_FLUSH_EN
    flush      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, sink always ready.
    out_ready = 1'b1;
    pops = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check_words(1, L, 40);
    chk("pop_count_1", 64'(pops), 64'd4);
    chk("fifo_drained", 64'(fcnt), 64'd0);

    // Backpressure: first word held, no extra pops.
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (20) tick();
    chk("held_pops", 64'(pops - p0), 64'd4);
    chk("held_valid", 64'(out_valid), 64'd1);
    chk("held_no_hs", 64'(got_q.size()), 64'd0);
    hs_q.delete();
    out_ready = 1'b1;
    check_words(2, L, 40);
    if (hs_q.size() >= 2)
      chk("throughput", 64'(hs_q[1] - hs_q[0]), 64'(L + 2));

    // Partial word across an empty gap.
    push(8'hA1); push(8'hA2);
    repeat (3) tick();
    busy_low = 0;
    repeat (10) tick();
    chk("gap_busy", 64'(busy_low), 64'd0);
    chk("gap_no_word", 64'(got_q.size()), 64'd0);
    push(8'hA3); push(8'hA4);
    check_words(1, L, 40);

    // Asynchronous reset mid-word.
    push(8'h51); push(8'h52);
    repeat (4) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    gotb_q.delete();
    hold_prev = 0;
    push(8'h55); push(8'h56); push(8'h57); push(8'h58);
    check_words(1, L, 40);

`ifdef PACKER_FLUSH_EN
    // Flush a 3-byte partial word; D1 waits in the FIFO.
    out_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (4) tick();
    flush = 1'b1;
    push(8'hD1);
    flush = 1'b0;
    p0 = pops;
    repeat (6) tick();
    chk("flush_no_pops", 64'(pops - p0), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    check_words(1, 3, 40);
    push(8'hD2); push(8'hD3); push(8'hD4);
    check_words(1, L, 40);
`endif

    // Random bytes, empty toggling, random backpressure.
    tog = 1;
    rnd = 1;
    for (int i = 0; i < 6 * L; i++) push(8'($urandom));
    check_words(6, L, 2000);
    tog = 0;
    rnd = 0;
    hide = 1'b0;
    out_ready = 1'b1;
    chk("model_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
